// File: rtl/mcycle_ctrl_pkg.sv
// mcycle_ctrl_pkg: shared state codes, opcode/funct constants, control
// encodings and the DECODE dispatch helper for the multi-cycle controller.
// Optional FPU support is enabled by defining MCU_FPU_EN.
package mcycle_ctrl_pkg;

    typedef enum logic [5:0] {
        ST_FETCH  = 6'd0,
        ST_FETCH2 = 6'd1,
        ST_DECODE = 6'd2,
        ST_MEMADR = 6'd3,
        ST_MEMRD  = 6'd4,
        ST_MEMRD2 = 6'd5,
        ST_MEMWB  = 6'd6,
        ST_MEMWR  = 6'd7,
        ST_REX    = 6'd8,
        ST_RWB    = 6'd9,
        ST_BR     = 6'd10,
        ST_IEX    = 6'd11,
        ST_IWB    = 6'd12,
        ST_JUMP   = 6'd13,
        ST_JR     = 6'd14,
        ST_FEX    = 6'd15,
        ST_FWB    = 6'd16,
        ST_OUT    = 6'd17,
        ST_TXW    = 6'd18,
        ST_INW    = 6'd19,
        ST_INWB   = 6'd20
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_FP    = 6'h11;
    localparam logic [5:0] OP_IN    = 6'h1a;
    localparam logic [5:0] OP_OUT   = 6'h1b;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_LWC1  = 6'h31;
    localparam logic [5:0] OP_SWC1  = 6'h39;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] FPU_FADD = 3'b000;
    localparam logic [2:0] FPU_FDIV = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRLUI = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_PC   = 2'b10;
    localparam logic [1:0] WB_UART = 2'b11;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       toggle_equal;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic [2:0] fpu_control;
        logic       alu_or_fpu;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       andi_ori;
        logic       shift;
        logic       shift_d;
        logic       bor_l;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] reg_concat;
        logic       out;
        logic       tx_start;
    } ctl_t;

    // Next state out of DECODE; anything unrecognised is treated as a NOP.
    function automatic state_e decode_dispatch(input logic [5:0] opcode,
                                               input logic [5:0] funct);
        state_e nxt;
        nxt = ST_FETCH;
        case (opcode)
            OP_LW, OP_SW: nxt = ST_MEMADR;
`ifdef MCU_FPU_EN
            OP_LWC1, OP_SWC1: nxt = ST_MEMADR;
            OP_FP: nxt = ST_FEX;
`endif
            OP_RTYPE: begin
                case (funct)
                    FN_JR: nxt = ST_JR;
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: nxt = ST_REX;
                    default: nxt = ST_FETCH;
                endcase
            end
            OP_BEQ, OP_BNE: nxt = ST_BR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt = ST_IEX;
            OP_J, OP_JAL: nxt = ST_JUMP;
            OP_OUT: nxt = ST_OUT;
            OP_IN: nxt = ST_INW;
            default: nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

    function automatic logic is_store(input logic [5:0] opcode);
        return (opcode == OP_SW) || (opcode == OP_SWC1);
    endfunction

    // Float-bank selects for {rs, rt, dst}.
    function automatic logic [2:0] fp_bank(input logic [5:0] opcode);
        logic [2:0] bank;
        case (opcode)
            OP_FP:   bank = 3'b111;
            OP_SWC1: bank = 3'b010;
            OP_LWC1: bank = 3'b001;
            default: bank = 3'b000;
        endcase
        return bank;
    endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// mcycle_ctrl_if: instruction fields, UART status and every datapath control
// driven by the multi-cycle controller. master = controller, slave = datapath.
interface mcycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       UBusy;
    logic       Rx_ready;

    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic       ToggleEqual;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic [2:0] FPUControl;
    logic       ALUorFPU;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       AndiOri;
    logic       Shift;
    logic       ShiftD;
    logic       BorL;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [2:0] RegConcat;
    logic       Out;
    logic       Tx_start;
    logic [5:0] state;

    modport master (
        input  opcode, funct, UBusy, Rx_ready,
        output IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual, PCSrc,
               ALUControl, FPUControl, ALUorFPU, ALUSrcA, ALUSrcB, AndiOri,
               Shift, ShiftD, BorL, RegWrite, RegDst, MemtoReg, RegConcat,
               Out, Tx_start, state
    );

    modport slave (
        output opcode, funct, UBusy, Rx_ready,
        input  IorD, MemWrite, IRWrite, PCWrite, Branch, ToggleEqual, PCSrc,
               ALUControl, FPUControl, ALUorFPU, ALUSrcA, ALUSrcB, AndiOri,
               Shift, ShiftD, BorL, RegWrite, RegDst, MemtoReg, RegConcat,
               Out, Tx_start, state
    );
endinterface

// File: rtl/mcycle_ctrl_dec.sv
// mcycle_ctrl_dec: combinational state + opcode/funct -> control decoder.
// FPU controls and register-bank selects exist only when MCU_FPU_EN is defined.
module mcycle_ctrl_dec
    import mcycle_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ubusy,
    output ctl_t       ctl
);

    // Moore decode per state; Tx_start alone follows UBusy directly.
    always_comb begin
        ctl = '0;
        case (state)
            ST_FETCH2: begin
                ctl.ir_write    = 1'b1;
                ctl.pc_write    = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.pc_src      = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctl.alu_src_b   = SRCB_BRLUI;
                ctl.alu_control = ALU_ADD;
            end
            ST_MEMADR: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.alu_control = ALU_ADD;
            end
            ST_MEMRD: ctl.iord = 1'b1;
            ST_MEMWB: begin
                ctl.reg_dst    = DST_RT;
                ctl.mem_to_reg = WB_MEM;
                ctl.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
            end
            ST_REX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_RT;
                case (funct)
                    FN_SUB: ctl.alu_control = ALU_SUB;
                    FN_AND: ctl.alu_control = ALU_AND;
                    FN_OR:  ctl.alu_control = ALU_OR;
                    FN_SLT: ctl.alu_control = ALU_SLT;
                    FN_SLL: begin
                        ctl.shift       = 1'b1;
                        ctl.alu_control = ALU_ADD;
                    end
                    FN_SRL: begin
                        ctl.shift       = 1'b1;
                        ctl.shift_d     = 1'b1;
                        ctl.alu_control = ALU_ADD;
                    end
                    default: ctl.alu_control = ALU_ADD;
                endcase
            end
            ST_RWB: begin
                ctl.reg_dst   = DST_RD;
                ctl.reg_write = 1'b1;
            end
            ST_BR: begin
                ctl.alu_src_a    = 1'b1;
                ctl.alu_src_b    = SRCB_RT;
                ctl.alu_control  = ALU_SUB;
                ctl.branch       = 1'b1;
                ctl.pc_src       = PCSRC_ALUOUT;
                ctl.toggle_equal = (opcode == OP_BNE);
            end
            ST_IEX: begin
                ctl.alu_src_a = 1'b1;
                case (opcode)
                    OP_ANDI: begin
                        ctl.alu_src_b   = SRCB_IMM;
                        ctl.andi_ori    = 1'b1;
                        ctl.alu_control = ALU_AND;
                    end
                    OP_ORI: begin
                        ctl.alu_src_b   = SRCB_IMM;
                        ctl.andi_ori    = 1'b1;
                        ctl.alu_control = ALU_OR;
                    end
                    OP_LUI: begin
                        ctl.alu_src_b   = SRCB_BRLUI;
                        ctl.bor_l       = 1'b1;
                        ctl.alu_control = ALU_ADD;
                    end
                    default: begin
                        ctl.alu_src_b   = SRCB_IMM;
                        ctl.alu_control = ALU_ADD;
                    end
                endcase
            end
            ST_IWB: begin
                ctl.reg_dst   = DST_RT;
                ctl.reg_write = 1'b1;
            end
            ST_JUMP: begin
                ctl.pc_src   = PCSRC_JUMP;
                ctl.pc_write = 1'b1;
                if (opcode == OP_JAL) begin
                    ctl.reg_dst    = DST_R31;
                    ctl.mem_to_reg = WB_PC;
                    ctl.reg_write  = 1'b1;
                end
            end
            ST_JR: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_RT;
                ctl.alu_control = ALU_ADD;
                ctl.pc_src      = PCSRC_ALU;
                ctl.pc_write    = 1'b1;
            end
`ifdef MCU_FPU_EN
            ST_FEX: begin
                ctl.alu_or_fpu  = 1'b1;
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_RT;
                ctl.fpu_control = (funct > 6'd3) ? FPU_FADD : funct[2:0];
            end
            ST_FWB: begin
                ctl.reg_dst   = DST_RD;
                ctl.reg_write = 1'b1;
            end
`endif
            ST_OUT: ctl.out = 1'b1;
            ST_TXW: ctl.tx_start = ~ubusy;
            ST_INWB: begin
                ctl.reg_dst    = DST_RT;
                ctl.mem_to_reg = WB_UART;
                ctl.reg_write  = 1'b1;
            end
            default: ;
        endcase
`ifdef MCU_FPU_EN
        // Bank selects stay valid from DECODE to the end of the instruction.
        if (state != ST_FETCH && state != ST_FETCH2)
            ctl.reg_concat = fp_bank(opcode);
`endif
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle MIPS-style control FSM (state register, FEX
// latency counter, next-state logic). MCU_FPU_EN enables FP instructions.
//
//  state  | meaning
//  0  FETCH   | present PC to memory
//  1  FETCH2  | load IR, PC += 4
//  2  DECODE  | branch target, dispatch
//  3  MEMADR  | effective address
//  4  MEMRD   | memory read
//  5  MEMRD2  | read data settle
//  6  MEMWB   | load writeback
//  7  MEMWR   | store
//  8  REX     | R-type execute
//  9  RWB     | R-type writeback
//  10 BR      | beq/bne compare + branch
//  11 IEX     | immediate execute
//  12 IWB     | immediate writeback
//  13 JUMP    | j/jal
//  14 JR      | jump register
//  15 FEX     | FPU execute, FPU_LAT cycles
//  16 FWB     | FPU writeback
//  17 OUT     | latch rt into TX buffer
//  18 TXW     | wait for UART idle, start TX
//  19 INW     | wait for RX byte
//  20 INWB    | RX byte writeback
module mcycle_ctrl
    import mcycle_ctrl_pkg::*;
#(
    parameter int FPU_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mcycle_ctrl_if.master bus
);

    localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
    localparam logic [CW-1:0] FEX_LOAD = CW'(FPU_LAT - 1);

    state_e        state_q;
    state_e        state_nxt;
    logic [CW-1:0] fex_cnt;
    ctl_t          ctl_dec;
    ctl_t          ctl;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_nxt;
    end

    // FEX down-counter: loaded on dispatch, FWB follows at terminal count.
    always_ff @(posedge clk) begin
        if (rst)
            fex_cnt <= '0;
        else if (state_q == ST_DECODE && state_nxt == ST_FEX)
            fex_cnt <= FEX_LOAD;
        else if (state_q == ST_FEX && fex_cnt != '0)
            fex_cnt <= fex_cnt - 1'b1;
    end

    // Next-state logic; FEX is unreachable when FP dispatch is compiled out.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_FETCH:  state_nxt = ST_FETCH2;
            ST_FETCH2: state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = decode_dispatch(bus.opcode, bus.funct);
            ST_MEMADR: state_nxt = is_store(bus.opcode) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_nxt = ST_MEMRD2;
            ST_MEMRD2: state_nxt = ST_MEMWB;
            ST_REX:    state_nxt = ST_RWB;
            ST_IEX:    state_nxt = ST_IWB;
            ST_FEX:    state_nxt = (fex_cnt == '0) ? ST_FWB : ST_FEX;
            ST_OUT:    state_nxt = ST_TXW;
            ST_TXW:    state_nxt = bus.UBusy ? ST_TXW : ST_FETCH;
            ST_INW:    state_nxt = bus.Rx_ready ? ST_INWB : ST_INW;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    mcycle_ctrl_dec u_dec (
        .state  (state_q),
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .ubusy  (bus.UBusy),
        .ctl    (ctl_dec)
    );

    // Controls are held quiet while reset is asserted, whatever the state.
    assign ctl = rst ? '0 : ctl_dec;

    assign bus.IorD        = ctl.iord;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.PCWrite     = ctl.pc_write;
    assign bus.Branch      = ctl.branch;
    assign bus.ToggleEqual = ctl.toggle_equal;
    assign bus.PCSrc       = ctl.pc_src;
    assign bus.ALUControl  = ctl.alu_control;
    assign bus.FPUControl  = ctl.fpu_control;
    assign bus.ALUorFPU    = ctl.alu_or_fpu;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.AndiOri     = ctl.andi_ori;
    assign bus.Shift       = ctl.shift;
    assign bus.ShiftD      = ctl.shift_d;
    assign bus.BorL        = ctl.bor_l;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.RegConcat   = ctl.reg_concat;
    assign bus.Out         = ctl.out;
    assign bus.Tx_start    = ctl.tx_start;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed, table-driven bench for mcycle_ctrl plus hand
// sequences for reset mid-instruction and the UART wait states.
module tb_mcycle_ctrl;

    localparam int FPU_LAT = 4;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       toggle_equal;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic [2:0] fpu_control;
        logic       alu_or_fpu;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       andi_ori;
        logic       shift;
        logic       shift_d;
        logic       bor_l;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [2:0] reg_concat;
        logic       out;
        logic       tx_start;
    } exp_t;

    typedef int seq_t[10];

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       ub;
        logic       rx;
        int         n;
        seq_t       seq;
        int         probe;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    vec_t v;
    exp_t e;
    seq_t s;

    mcycle_ctrl_if bus ();

    mcycle_ctrl #(.FPU_LAT(FPU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t snap();
        exp_t g;
        g.iord         = bus.IorD;
        g.mem_write    = bus.MemWrite;
        g.ir_write     = bus.IRWrite;
        g.pc_write     = bus.PCWrite;
        g.branch       = bus.Branch;
        g.toggle_equal = bus.ToggleEqual;
        g.pc_src       = bus.PCSrc;
        g.alu_control  = bus.ALUControl;
        g.fpu_control  = bus.FPUControl;
        g.alu_or_fpu   = bus.ALUorFPU;
        g.alu_src_a    = bus.ALUSrcA;
        g.alu_src_b    = bus.ALUSrcB;
        g.andi_ori     = bus.AndiOri;
        g.shift        = bus.Shift;
        g.shift_d      = bus.ShiftD;
        g.bor_l        = bus.BorL;
        g.reg_write    = bus.RegWrite;
        g.reg_dst      = bus.RegDst;
        g.mem_to_reg   = bus.MemtoReg;
        g.reg_concat   = bus.RegConcat;
        g.out          = bus.Out;
        g.tx_start     = bus.Tx_start;
        return g;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input int exp_s);
        n_checks++;
        if (bus.state !== 6'(exp_s)) begin
            n_errors++;
            $display("FAIL %s: state=%0d expected %0d", name, bus.state, exp_s);
        end
    endtask

    task automatic chk_ctl(input string name, input exp_t exp_c);
        exp_t got;
        got = snap();
        n_checks++;
        if (got !== exp_c) begin
            n_errors++;
            $display("FAIL %s: controls=%h expected %h", name, got, exp_c);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp_b);
        n_checks++;
        if (got !== exp_b) begin
            n_errors++;
            $display("FAIL %s: value=%b expected %b", name, got, exp_b);
        end
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (bus.state !== 6'(target) && k < budget) begin
            step();
            k++;
        end
        chk_state({name, "_reach"}, target);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic ub, input logic rx);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.UBusy    = ub;
        bus.Rx_ready = rx;
        #1;
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic ub, input logic rx, input int n,
                           input seq_t sq, input int probe, input exp_t ex);
        vec_t nv;
        nv.name  = name;
        nv.op    = op;
        nv.fn    = fn;
        nv.ub    = ub;
        nv.rx    = rx;
        nv.n     = n;
        nv.seq   = sq;
        nv.probe = probe;
        nv.e     = ex;
        vecs.push_back(nv);
    endtask

    initial begin
        // ---------------- vector table ----------------
        s = '{0, 1, 2, 8, 9, 0, 0, 0, 0, 0};
        e = '0;
        add_vec("fetch", 6'h00, 6'h20, 1'b0, 1'b0, 6, s, 0, e);
        e = '0; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        add_vec("fetch2", 6'h00, 6'h20, 1'b0, 1'b0, 6, s, 1, e);
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b010;
        add_vec("add_rex", 6'h00, 6'h20, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b110;
        add_vec("sub_rex", 6'h00, 6'h22, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.reg_write = 1; e.reg_dst = 2'b01;
        add_vec("sub_rwb", 6'h00, 6'h22, 1'b0, 1'b0, 6, s, 4, e);
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b000;
        add_vec("and_rex", 6'h00, 6'h24, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b001;
        add_vec("or_rex", 6'h00, 6'h25, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b111;
        add_vec("slt_rex", 6'h00, 6'h2a, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.shift = 1; e.alu_control = 3'b010;
        add_vec("sll_rex", 6'h00, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.shift = 1; e.shift_d = 1; e.alu_control = 3'b010;
        add_vec("srl_rex", 6'h00, 6'h02, 1'b0, 1'b0, 6, s, 3, e);

        s = '{0, 1, 2, 14, 0, 0, 0, 0, 0, 0};
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b010; e.pc_write = 1;
        add_vec("jr", 6'h00, 6'h08, 1'b0, 1'b0, 5, s, 3, e);

        s = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0};
        e = '0; e.alu_src_b = 2'b11; e.alu_control = 3'b010;
        add_vec("bad_funct_decode", 6'h00, 6'h3f, 1'b0, 1'b0, 4, s, 2, e);
        e = '0;
        add_vec("bad_opcode", 6'h3f, 6'h20, 1'b0, 1'b0, 4, s, 3, e);

        s = '{0, 1, 2, 10, 0, 0, 0, 0, 0, 0};
        e = '0; e.alu_src_a = 1; e.alu_control = 3'b110; e.branch = 1; e.pc_src = 2'b01;
        e.toggle_equal = 1;
        add_vec("bne_br", 6'h05, 6'h00, 1'b0, 1'b0, 5, s, 3, e);
        e.toggle_equal = 0;
        add_vec("beq_br", 6'h04, 6'h00, 1'b0, 1'b0, 5, s, 3, e);

        s = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0};
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
        add_vec("lw_memadr", 6'h23, 6'h00, 1'b0, 1'b0, 8, s, 3, e);
        e = '0; e.iord = 1;
        add_vec("lw_memrd", 6'h23, 6'h00, 1'b0, 1'b0, 8, s, 4, e);
        e = '0;
        add_vec("lw_memrd2", 6'h23, 6'h00, 1'b0, 1'b0, 8, s, 5, e);
        e = '0; e.mem_to_reg = 2'b01; e.reg_write = 1;
        add_vec("lw_memwb", 6'h23, 6'h00, 1'b0, 1'b0, 8, s, 6, e);

        s = '{0, 1, 2, 3, 7, 0, 0, 0, 0, 0};
        e = '0; e.iord = 1; e.mem_write = 1;
        add_vec("sw_memwr", 6'h2b, 6'h00, 1'b0, 1'b0, 6, s, 4, e);

        s = '{0, 1, 2, 11, 12, 0, 0, 0, 0, 0};
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010;
        add_vec("addi_iex", 6'h08, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.andi_ori = 1; e.alu_control = 3'b000;
        add_vec("andi_iex", 6'h0c, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e.alu_control = 3'b001;
        add_vec("ori_iex", 6'h0d, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b11; e.bor_l = 1; e.alu_control = 3'b010;
        add_vec("lui_iex", 6'h0f, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.reg_write = 1;
        add_vec("addi_iwb", 6'h08, 6'h00, 1'b0, 1'b0, 6, s, 4, e);

        s = '{0, 1, 2, 13, 0, 0, 0, 0, 0, 0};
        e = '0; e.pc_src = 2'b10; e.pc_write = 1;
        add_vec("j", 6'h02, 6'h00, 1'b0, 1'b0, 5, s, 3, e);
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.reg_write = 1;
        add_vec("jal", 6'h03, 6'h00, 1'b0, 1'b0, 5, s, 3, e);

        s = '{0, 1, 2, 17, 18, 0, 0, 0, 0, 0};
        e = '0; e.out = 1;
        add_vec("out", 6'h1b, 6'h00, 1'b0, 1'b0, 6, s, 3, e);
        e = '0; e.tx_start = 1;
        add_vec("out_tx", 6'h1b, 6'h00, 1'b0, 1'b0, 6, s, 4, e);

        s = '{0, 1, 2, 19, 20, 0, 0, 0, 0, 0};
        e = '0;
        add_vec("in_inw", 6'h1a, 6'h00, 1'b0, 1'b1, 6, s, 3, e);
        e = '0; e.mem_to_reg = 2'b11; e.reg_write = 1;
        add_vec("in_inwb", 6'h1a, 6'h00, 1'b0, 1'b1, 6, s, 4, e);

`ifdef MCU_FPU_EN
        s = '{0, 1, 2, 15, 15, 15, 15, 16, 0, 0};
        e = '0; e.alu_or_fpu = 1; e.alu_src_a = 1; e.fpu_control = 3'b010; e.reg_concat = 3'b111;
        add_vec("fmul_fex_first", 6'h11, 6'h02, 1'b0, 1'b0, 9, s, 3, e);
        add_vec("fmul_fex_last", 6'h11, 6'h02, 1'b0, 1'b0, 9, s, 6, e);
        e.fpu_control = 3'b011;
        add_vec("fdiv_fex", 6'h11, 6'h03, 1'b0, 1'b0, 9, s, 4, e);
        e.fpu_control = 3'b000;
        add_vec("fbad_fex", 6'h11, 6'h05, 1'b0, 1'b0, 9, s, 3, e);
        e = '0; e.reg_dst = 2'b01; e.reg_write = 1; e.reg_concat = 3'b111;
        add_vec("fp_fwb", 6'h11, 6'h02, 1'b0, 1'b0, 9, s, 7, e);
        e = '0; e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.reg_concat = 3'b111;
        add_vec("fp_decode", 6'h11, 6'h02, 1'b0, 1'b0, 9, s, 2, e);
        e = '0; e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
        add_vec("fp_fetch2_nobank", 6'h11, 6'h02, 1'b0, 1'b0, 9, s, 1, e);
        s = '{0, 1, 2, 3, 4, 5, 6, 0, 0, 0};
        e = '0; e.mem_to_reg = 2'b01; e.reg_write = 1; e.reg_concat = 3'b001;
        add_vec("lwc1_memwb", 6'h31, 6'h00, 1'b0, 1'b0, 8, s, 6, e);
        s = '{0, 1, 2, 3, 7, 0, 0, 0, 0, 0};
        e = '0; e.iord = 1; e.mem_write = 1; e.reg_concat = 3'b010;
        add_vec("swc1_memwr", 6'h39, 6'h00, 1'b0, 1'b0, 6, s, 4, e);
`else
        s = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0};
        e = '0; e.alu_src_b = 2'b11; e.alu_control = 3'b010;
        add_vec("fp_nop_decode", 6'h11, 6'h02, 1'b0, 1'b0, 4, s, 2, e);
        e = '0;
        add_vec("lwc1_nop", 6'h31, 6'h00, 1'b0, 1'b0, 4, s, 3, e);
        add_vec("swc1_nop", 6'h39, 6'h00, 1'b0, 1'b0, 4, s, 3, e);
`endif

        // ---------------- reset ----------------
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        chk_state("reset_state", 0);
        chk_ctl("reset_ctl", '0);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            wait_state(0, 50, v.name);
            drive(v.op, v.fn, v.ub, v.rx);
            for (int i = 0; i < v.n; i++) begin
                if (i > 0) step();
                chk_state($sformatf("%s_seq%0d", v.name, i), v.seq[i]);
                chk_bit($sformatf("%s_memwrite%0d", v.name, i), bus.MemWrite, v.seq[i] == 7);
                if (i == v.probe) chk_ctl(v.name, v.e);
            end
        end

        // ---------------- reset in the middle of MEMRD ----------------
        wait_state(0, 50, "rst_mid_start");
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        wait_state(4, 10, "rst_mid_memrd");
        rst = 1'b1;
        #1;
        chk_ctl("rst_mid_ctl_during", '0);
        step();
        chk_state("rst_mid_state", 0);
        chk_ctl("rst_mid_ctl", '0);
        rst = 1'b0;
        #1;
        chk_ctl("rst_mid_fetch_ctl", '0);
        step();
        chk_state("rst_mid_fetch2", 1);
        step();
        chk_state("rst_mid_decode", 2);

        // ---------------- out with UART busy for 3 cycles ----------------
        wait_state(0, 50, "txbusy_start");
        drive(6'h1b, 6'h00, 1'b1, 1'b0);
        wait_state(18, 10, "txbusy_txw");
        for (int j = 0; j < 3; j++) begin
            chk_state($sformatf("txbusy_hold%0d", j), 18);
            chk_bit($sformatf("txbusy_txstart%0d", j), bus.Tx_start, 1'b0);
            step();
        end
        bus.UBusy = 1'b0;
        #1;
        chk_state("txbusy_release_state", 18);
        chk_bit("txbusy_release_txstart", bus.Tx_start, 1'b1);
        step();
        chk_state("txbusy_done", 0);
        chk_bit("txbusy_done_txstart", bus.Tx_start, 1'b0);

        // ---------------- in waiting for Rx_ready ----------------
        drive(6'h1a, 6'h00, 1'b0, 1'b0);
        wait_state(19, 10, "rxwait_inw");
        for (int j = 0; j < 3; j++) begin
            chk_state($sformatf("rxwait_hold%0d", j), 19);
            chk_bit($sformatf("rxwait_regwrite%0d", j), bus.RegWrite, 1'b0);
            step();
        end
        bus.Rx_ready = 1'b1;
        step();
        bus.Rx_ready = 1'b0;
        #1;
        chk_state("rxwait_inwb", 20);
        e = '0; e.mem_to_reg = 2'b11; e.reg_write = 1;
        chk_ctl("rxwait_inwb_ctl", e);
        step();
        chk_state("rxwait_done", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
